scroll_message_feeder: RTL and testbench

//  Upstream feeder for the four-digit LED driver: holds a 16-entry x 4-bit message
//  and presents a 4-character window of it on an3char..an0char, one nibble per digit.

---
 rtl/scroll_message_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_scroll_message_feeder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_message_feeder.sv
// Scrolling message feeder for the four-digit LED driver.
// Holds a 16-character message (4-bit codes) and presents a 4-character
// window starting at offset. The window advances by one on a periodic timer
// tick or on a debounced button press. The message can be rewritten while the
// design runs. All outputs are registered, so the downstream decoder sees no
// glitches.
module scroll_message_feeder #(
  parameter int TICK_COUNT      = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter bit AUTO_SCROLL     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       freeze,
  input  logic       load_en,
  input  logic [3:0] load_addr,
  input  logic [3:0] load_data,
  output logic [3:0] an3char,
  output logic [3:0] an2char,
  output logic [3:0] an1char,
  output logic [3:0] an0char,
  output logic [3:0] offset,
  output logic       step
);

  localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_COUNT - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  // Button synchroniser
  logic sync1_reg;
  logic sync2_reg;

  // Debounce FSM
  db_state_t db_state_reg;
  db_state_t db_state_next;
  logic [DW-1:0] db_count_reg;
  logic [DW-1:0] db_count_next;
  logic btn_evt;

  // Timer
  logic [TW-1:0] tick_count_reg;
  logic tick_evt;

  // Window position and step pulse
  logic [3:0] offset_reg;
  logic step_reg;
  logic step_req;

  // Message storage and registered window
  logic [3:0] msg_reg [16];
  logic [3:0] an_reg [4];
  logic [3:0] an_next [4];

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (reset) begin
      db_state_reg <= IDLE;
      db_count_reg <= '0;
    end else begin
      db_state_reg <= db_state_next;
      db_count_reg <= db_count_next;
    end
  end

  // Debounce next-state: a level must hold for the full count before it is
  // accepted; a press event fires once on acceptance, never while held
  always_comb begin
    db_state_next = db_state_reg;
    db_count_next = db_count_reg;
    btn_evt       = 1'b0;
    case (db_state_reg)
      IDLE: begin
        if (sync2_reg) begin
          db_state_next = PRESS_WAIT;
          db_count_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_reg) begin
          db_state_next = IDLE;
        end else if (db_count_reg == DB_LAST) begin
          db_state_next = PRESSED;
          btn_evt       = 1'b1;
        end else begin
          db_count_next = db_count_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync2_reg) begin
          db_state_next = RELEASE_WAIT;
          db_count_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_reg) begin
          db_state_next = PRESSED;
        end else if (db_count_reg == DB_LAST) begin
          db_state_next = IDLE;
        end else begin
          db_count_next = db_count_reg + 1'b1;
        end
      end
      default: begin
        db_state_next = IDLE;
        db_count_next = '0;
      end
    endcase
  end

  // Free-running scroll timer; freeze holds the count where it is
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count_reg <= '0;
    end else if (!freeze) begin
      if (tick_count_reg == TICK_LAST) begin
        tick_count_reg <= '0;
      end else begin
        tick_count_reg <= tick_count_reg + 1'b1;
      end
    end
  end

  assign tick_evt = AUTO_SCROLL && !freeze && (tick_count_reg == TICK_LAST);

  // A coincident tick and press still advance by a single position
  assign step_req = tick_evt | btn_evt;

  // Window offset advance with natural 4-bit wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      offset_reg <= 4'd0;
      step_reg   <= 1'b0;
    end else begin
      step_reg <= step_req;
      if (step_req) begin
        offset_reg <= offset_reg + 4'd1;
      end
    end
  end

  // Message memory: identity pattern on reset, single write port otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        msg_reg[i] <= 4'(i);
      end
    end else if (load_en) begin
      msg_reg[load_addr] <= load_data;
    end
  end

  // Window select from the current message and offset, wrapping past index 15
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      an_next[k] = msg_reg[offset_reg + 4'(k)];
    end
  end

  // Registered window so the decoder sees clean, single transitions
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        an_reg[k] <= 4'(k);
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        an_reg[k] <= an_next[k];
      end
    end
  end

  assign an3char = an_reg[0];
  assign an2char = an_reg[1];
  assign an1char = an_reg[2];
  assign an0char = an_reg[3];
  assign offset  = offset_reg;
  assign step    = step_reg;

endmodule

// File: tb/tb_scroll_message_feeder.sv
// Bench for scroll_message_feeder: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_scroll_message_feeder;

  localparam int TC = 8;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic       freeze = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [3:0] load_data = 4'd0;
  logic [3:0] an3char, an2char, an1char, an0char, offset;
  logic       step;

  scroll_message_feeder #(
    .TICK_COUNT(TC),
    .DEBOUNCE_CYCLES(DB),
    .AUTO_SCROLL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .freeze(freeze),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .an3char(an3char),
    .an2char(an2char),
    .an1char(an1char),
    .an0char(an0char),
    .offset(offset),
    .step(step)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: message array, window position, timer count, and a
  // level-acceptance view of the debouncer (a new level is accepted once the
  // synchronised button has differed from the accepted level for DB+1 samples)
  int m_msg [16];
  int m_off, m_tick, m_s1, m_s2, m_acc, m_run;
  logic [3:0]  e_off;
  logic        e_step;
  logic [15:0] e_win;

  typedef struct {
    logic rst, b, frz, le;
    logic [3:0] la, ld;
    logic [3:0] x_off;
    logic x_step;
    logic [15:0] x_win;
  } vec_t;
  vec_t vecs [20];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge(input logic rst, input logic b, input logic frz,
                                     input logic le, input logic [3:0] la, input logic [3:0] ld);
    int seen;
    bit tick_evt, btn_evt, stp;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_msg[i] = i;
      m_off = 0; m_tick = 0; m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0;
      e_off = 4'd0; e_step = 1'b0; e_win = 16'h0123;
      return;
    end
    e_win = {4'(m_msg[m_off % 16]), 4'(m_msg[(m_off + 1) % 16]),
             4'(m_msg[(m_off + 2) % 16]), 4'(m_msg[(m_off + 3) % 16])};
    tick_evt = (m_tick == TC - 1) && !frz;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(b);
    btn_evt = 1'b0;
    if (seen != m_acc) begin
      m_run++;
      if (m_run == DB + 1) begin
        m_acc = seen;
        m_run = 0;
        btn_evt = (seen == 1);
      end
    end else begin
      m_run = 0;
    end
    if (!frz) m_tick = (m_tick + 1) % TC;
    stp = tick_evt || btn_evt;
    if (stp) m_off = (m_off + 1) % 16;
    e_step = stp;
    e_off = 4'(m_off);
    if (le) m_msg[la] = int'(ld);
  endfunction

  task automatic do_cycle(input logic rst, input logic b, input logic frz,
                          input logic le, input logic [3:0] la, input logic [3:0] ld);
    reset = rst; btn = b; freeze = frz; load_en = le; load_addr = la; load_data = ld;
    model_edge(rst, b, frz, le, la, ld);
    @(posedge clk);
    #1;
    $display("cyc rst=%0b btn=%0b frz=%0b ld=%0b@%0h=%0h -> off=%0h step=%0b win=%h%h%h%h",
             rst, b, frz, le, la, ld, offset, step, an3char, an2char, an1char, an0char);
    check("model", {11'd0, offset, step, an3char, an2char, an1char, an0char},
          {11'd0, e_off, e_step, e_win});
  endtask

  initial begin
    int hits, at, extra, held, waited, o0;
    bit found;
    logic b_r;
    int hold;

    // Directed table: reset, first timer step, load, load coincident with step, reset restore
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0123};
    for (int i = 1; i <= 7; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0123};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0123};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 16'h1234};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd9, 4'd1, 1'b0, 16'h1234};
    for (int i = 11; i <= 15; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 16'h1934};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'hA, 4'd2, 1'b1, 16'h1934};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 16'h9A45};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0123};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 16'h0123};

    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      do_cycle(vecs[i].rst, vecs[i].b, vecs[i].frz, vecs[i].le, vecs[i].la, vecs[i].ld);
      check($sformatf("vec%0d", i), {11'd0, offset, step, an3char, an2char, an1char, an0char},
            {11'd0, vecs[i].x_off, vecs[i].x_step, vecs[i].x_win});
    end

    // Bounce: a 2-cycle pulse must never be accepted
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b0, (i < 2), 1'b1, 1'b0, 4'd0, 4'd0);
      if (step) hits++;
    end
    check("bounce_steps", hits, 0);

    // Clean press: one step, 6 cycles after the rise, none while held or on release
    hits = 0; at = -1; extra = 0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      if (step) begin hits++; at = i; end
    end
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      if (step) extra++;
    end
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      if (step) extra++;
    end
    check("press_steps", hits, 1);
    check("press_latency", at, 6);
    check("hold_steps", extra, 0);

    // Freeze holds the timer; release resumes from the held count
    o0 = m_off;
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      if (step) hits++;
    end
    check("freeze_steps", hits, 0);
    check("freeze_offset", offset, o0);
    held = m_tick;
    waited = -1;
    for (int i = 0; i < 10 && waited < 0; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      if (step) waited = i;
    end
    check("resume_delay", waited, TC - 1 - held);

    // Align the button acceptance with a timer tick: single advance only
    found = 1'b0;
    for (int i = 0; i < 2 * TC && !found; i++) begin
      if (m_tick == 1) found = 1'b1;
      else do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    check("align_found", found, 1'b1);
    o0 = m_off;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      if (i == 6) begin
        check("coinc_step", step, 1'b1);
        check("coinc_offset", offset, (o0 + 1) % 16);
      end
      if (i == 7) begin
        check("coinc_pulse_end", step, 1'b0);
        check("coinc_offset_hold", offset, (o0 + 1) % 16);
      end
    end
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);

    // Writes, then scroll to offset 7, then reset in the middle of a press
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 4'(15 - i));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_off == 7) found = 1'b1;
      else do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    check("reach_off7", found, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    check("rst_offset", offset, 4'd0);
    check("rst_window", {an3char, an2char, an1char, an0char}, 16'h0123);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      if (i == 0) check("msg_restored", {an3char, an2char, an1char, an0char}, 16'h0123);
      if (step) hits++;
    end
    check("post_rst_steps", hits, 0);

    // Randomized traffic against the model
    b_r = 1'b0;
    hold = 1;
    for (int i = 0; i < 800; i++) begin
      hold--;
      if (hold <= 0) begin
        b_r = ~b_r;
        hold = $urandom_range(1, 12);
      end
      do_cycle(($urandom_range(0, 199) == 0), b_r, ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
